serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor; the inverse-operation companion to the team's combinational adder cells.
- Computes a − b one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Uses a start/busy/done handshake.
- Area-light option for arithmetic datapaths where latency is acceptable.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- busy  output  1  high while operation in progress (RUN)
- done  output  1  one-cycle pulse: result valid
- diff  output  WIDTH  (a − b) mod 2^WIDTH, registered
- borrow_out  output  1  final borrow; 1 iff a < b (unsigned)

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE; busy=0, done=0, diff=0, borrow_out=0.
  - Internal shift registers, borrow flop and bit counter cleared.
  - Any operation in flight is abandoned; no done pulse follows.
- States: IDLE, RUN, DONE; encoding is free.
- IDLE:
  - busy=0.
  - start=1 at edge k: a and b latched into shift registers, borrow flop=0, counter=0, go to RUN.
  - start=0: stay in IDLE.
- RUN (edges k+1 .. k+WIDTH): busy=1. Each edge:
  - Bit inputs: x=a_sh[0], y=b_sh[0], c=borrow.
  - d = x ^ y ^ c.
  - borrow_next = (~x & y) | (~(x ^ y) & c).
  - d shifts into the result shift register from the MSB end; a_sh and b_sh shift right; counter increments.
  - On the WIDTH-th RUN edge: diff ← assembled result, borrow_out ← borrow_next, go to DONE.
- DONE: done=1, busy=0 for exactly one cycle, then unconditionally IDLE.
- Latency:
  - start accepted at edge k → busy high cycles k+1..k+WIDTH.
  - done high during the cycle after edge k+WIDTH.
  - Total WIDTH+1 cycles start-to-done.
- Output stability:
  - diff/borrow_out change only on entry to DONE or on reset.
  - They hold their values through IDLE and through the next RUN until the next DONE.
- start handling:
  - Ignored in RUN and DONE; no queuing.
  - Changes on a/b after capture have no effect.
  - Back-to-back operation: start asserted in the IDLE cycle immediately after DONE is accepted. Minimum issue interval is WIDTH+2 cycles.
- busy and done are never high together.

Test Plan:
- WIDTH=8: a=8'h5A, b=8'h23, start one cycle → busy high 8 cycles, then done pulse 1 cycle; diff=8'h37, borrow_out=0.
- a=8'h10, b=8'h20 → diff=8'hF0, borrow_out=1. Then a=8'h00, b=8'h01 → diff=8'hFF, borrow_out=1. Then a=b=8'hFF → diff=8'h00, borrow_out=0.
- start re-pulsed on RUN cycle 3 with a=8'h01, b=8'h01 → ignored; result of the original operation (8'h5A−8'h23=8'h37) appears with done exactly 9 cycles after the original start. a/b changed mid-RUN also have no effect.
- rst_n driven low asynchronously mid-RUN (between edges) → busy, done, diff, borrow_out go to 0 immediately. No done pulse occurs; a fresh start afterwards completes normally.
- start held high continuously with a=8'h80, b=8'h7F:
  - done pulses every 10 cycles; diff=8'h01, borrow_out=0.
  - diff stays stable between done pulses.
- Randomized self-check, WIDTH=8 and WIDTH=16, 500 pairs → diff==(a−b) mod 2^WIDTH and borrow_out==(a<b) on every done.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// with a single full-subtractor cell and a registered borrow. start/busy/done
// handshake; result and final borrow are held until the next completion.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             bout_q, bout_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   logic x, y, c, d_bit, borrow_nxt, last_bit;

   // Full-subtractor cell on the current operand LSBs and the stored borrow.
   always_comb begin
      x          = a_sh_q[0];
      y          = b_sh_q[0];
      c          = borrow_q;
      d_bit      = x ^ y ^ c;
      borrow_nxt = (~x & y) | (~(x ^ y) & c);
      last_bit   = (cnt_q == CntW'(WIDTH - 1));
   end

   // Next-state logic: capture on start, shift during RUN, publish on the last bit.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_sh_d   = a;
               b_sh_d   = b;
               borrow_d = 1'b0;
               cnt_d    = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
            res_d    = {d_bit, res_q[WIDTH-1:1]};
            borrow_d = borrow_nxt;
            cnt_d    = cnt_q + 1'b1;
            if (last_bit) begin
               diff_d  = {d_bit, res_q[WIDTH-1:1]};
               bout_d  = borrow_nxt;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy       = (state_q == StRun);
   assign done       = (state_q == StDone);
   assign diff       = diff_q;
   assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start8 = 1'b0, start16 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy8, done8, bo8, busy16, done16, bo16;
   logic [7:0]  diff8;
   logic [15:0] diff16;

   logic [8:0]  exp8[$];
   logic [16:0] exp16[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          ncomp = 0;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
   );

   serial_subtractor #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bo16)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      ncomp++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: plain modular subtraction and unsigned compare.
   task automatic push(input int w, input logic [15:0] av, input logic [15:0] bv);
      logic [7:0]  a_s, b_s;
      a_s = av[7:0];
      b_s = bv[7:0];
      if (w == 8) exp8.push_back({(a_s < b_s), 8'(a_s - b_s)});
      else        exp16.push_back({(av < bv), 16'(av - bv)});
      vectors++;
   endtask

   function automatic logic cur_busy(input int w);
      return (w == 8) ? busy8 : busy16;
   endfunction

   function automatic logic cur_done(input int w);
      return (w == 8) ? done8 : done16;
   endfunction

   // One operation with latency checks; operands are scrambled mid-run.
   task automatic op(input int w, input logic [15:0] av, input logic [15:0] bv);
      @(negedge clk);
      push(w, av, bv);
      if (w == 8) begin start8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; end
      else begin start16 = 1'b1; a16 = av; b16 = bv; end
      for (int i = 1; i <= w + 1; i++) begin
         @(negedge clk);
         if (i == 1) begin start8 = 1'b0; start16 = 1'b0; end
         if (i == 2) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom);
         end
         if (i <= w) chk("busy_in_run", 32'(cur_busy(w)), 32'd1);
         else begin
            chk("done_latency", 32'(cur_done(w)), 32'd1);
            chk("busy_in_done", 32'(cur_busy(w)), 32'd0);
         end
      end
   endtask

   // Monitors: pop the scoreboard on every done pulse.
   always @(negedge clk) begin
      logic [8:0] e;
      if (rst_n) begin
         if (busy8 && done8) chk("busy_done_overlap8", 32'd1, 32'd0);
         if (done8) begin
            if (exp8.size() == 0) chk("unexpected_done8", 32'd1, 32'd0);
            else begin
               e = exp8.pop_front();
               chk("diff8", 32'(diff8), 32'(e[7:0]));
               chk("borrow8", 32'(bo8), 32'(e[8]));
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [16:0] e;
      if (rst_n) begin
         if (busy16 && done16) chk("busy_done_overlap16", 32'd1, 32'd0);
         if (done16) begin
            if (exp16.size() == 0) chk("unexpected_done16", 32'd1, 32'd0);
            else begin
               e = exp16.pop_front();
               chk("diff16", 32'(diff16), 32'(e[15:0]));
               chk("borrow16", 32'(bo16), 32'(e[16]));
            end
         end
      end
   end

   initial begin
      int dn[$];
      logic [15:0] av, bv;

      // Reset values
      #1 rst_n = 1'b0;
      #2;
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_diff", 32'(diff8), 32'd0);
      chk("rst_borrow", 32'(bo8), 32'd0);
      chk("rst_diff16", 32'(diff16), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed operands, issued back to back
      op(8, 16'h5A, 16'h23);
      op(8, 16'h10, 16'h20);
      op(8, 16'h00, 16'h01);
      op(8, 16'hFF, 16'hFF);

      // start re-pulsed on RUN cycle 3 is ignored; operands changed mid-run
      @(negedge clk);
      push(8, 16'h5A, 16'h23);
      start8 = 1'b1; a8 = 8'h5A; b8 = 8'h23;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         if (i == 1) start8 = 1'b0;
         if (i == 3) begin start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; end
         if (i == 4) begin start8 = 1'b0; a8 = 8'hC3; b8 = 8'h99; end
         if (i < 9) chk("restart_busy", 32'(busy8), 32'd1);
         else chk("restart_done_at_9", 32'(done8), 32'd1);
      end
      @(negedge clk);
      chk("restart_idle_done", 32'(done8), 32'd0);
      chk("restart_idle_busy", 32'(busy8), 32'd0);

      // Asynchronous reset mid-RUN
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy8), 32'd0);
      chk("midrst_done", 32'(done8), 32'd0);
      chk("midrst_diff", 32'(diff8), 32'd0);
      chk("midrst_borrow", 32'(bo8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         chk("no_done_after_rst", 32'(done8), 32'd0);
      end
      op(8, 16'h77, 16'h11);

      // start held high: done every WIDTH+2 cycles, diff stable in between
      @(negedge clk);
      repeat (3) push(8, 16'h80, 16'h7F);
      start8 = 1'b1; a8 = 8'h80; b8 = 8'h7F;
      for (int i = 1; i <= 40 && dn.size() < 3; i++) begin
         @(negedge clk);
         if (done8) begin
            dn.push_back(i);
            if (dn.size() == 3) start8 = 1'b0;
         end else if (dn.size() > 0) begin
            chk("hold_diff_stable", 32'(diff8), 32'h01);
            chk("hold_borrow_stable", 32'(bo8), 32'd0);
         end
      end
      chk("hold_done_count", 32'(dn.size()), 32'd3);
      if (dn.size() == 3) begin
         chk("hold_first_done", 32'(dn[0]), 32'd9);
         chk("hold_period_1", 32'(dn[1] - dn[0]), 32'd10);
         chk("hold_period_2", 32'(dn[2] - dn[1]), 32'd10);
      end

      // Randomized operands, with equal/zero/max corner pairs mixed in
      for (int w = 8; w <= 16; w += 8) begin
         for (int n = 0; n < 500; n++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            if (n % 16 == 0) bv = av;
            if (n % 16 == 1) av = '0;
            if (n % 16 == 2) bv = '1;
            op(w, av, bv);
         end
      end

      repeat (30) @(negedge clk);
      chk("sb8_drained", 32'(exp8.size()), 32'd0);
      chk("sb16_drained", 32'(exp16.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
